stim_sequencer: RTL and testbench
=================================

# stim_sequencer

Parametrised stimulus sequencer that drives reset, enable and direction into up to eight up/down counter channels under test. It is the next generation of our fixed counter stimulus generator. Phase lengths, channel count, seed and repeat mode are all parameters, and the random phase comes from a reproducible LFSR instead of `$random`. The block is synthesisable and sits beside the counter DUTs, either in the bench or on an FPGA self-test wrapper, where it issues start/stop and reports done.

## Interface
- NCH, 2, number of counter channels; 1..8 (each needs 2 LFSR bits).
- CNT_W, 8, phase counter width; every phase length must be < 2**CNT_W.
- RST_CYCLES, 1, cycles g_rst_n is held low after start; must be ≥1.
- UP_CYCLES, 2, cycles of directed count-up; 0 skips the phase.
- DN_CYCLES, 3, cycles of directed count-down; 0 skips the phase.
- RAND_CYCLES, 16, cycles of pseudo-random stimulus; 0 skips the phase.
- SEED, 16'hACE1, LFSR load value; must be nonzero.
- REPEAT, 0, 1 = loop UP→DN→RAND until stop; 0 = one pass then DONE.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request; honoured only in IDLE or DONE.
- stop  in  1  abort; any state → IDLE; takes priority over start.
- g_rst_n  out  1  reset to DUTs, active low.
- g_en  out  NCH  per-channel count enable.
- g_up_dn  out  NCH  per-channel direction; 1 = up.
- busy  out  1  high in RESET/UP/DN/RAND.
- done  out  1  high in DONE.

## Operation
- States: IDLE, RESET, UP, DN, RAND, DONE. All outputs are registered and update on the same edge as the state.
- rst_n low: state = IDLE; g_rst_n=0, g_en=0, g_up_dn=0, busy=0, done=0; LFSR = SEED; phase counter = 0.
- IDLE: g_rst_n=1, g_en=0, g_up_dn=0.
- IDLE/DONE with start=1 → RESET. LFSR is reloaded with SEED and the phase counter is cleared.
- RESET: g_rst_n=0, g_en=0, g_up_dn=0 for RST_CYCLES cycles.
- UP: g_rst_n=1, g_en=all 1, g_up_dn=all 1.
- DN: g_en=all 1, g_up_dn=all 0.
- RAND: g_en[i]=lfsr[2i], g_up_dn[i]=lfsr[2i+1], sampled from the current LFSR value. The LFSR advances once per RAND cycle.
- LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1. Shift left; new bit0 = b15^b13^b12^b10. It advances only in RAND.
- DONE: g_rst_n=1, g_en=0, g_up_dn=0, done=1. The block holds here until start or stop.
- Phase exit: when the phase counter reaches length−1, go to the next nonzero-length phase in the order UP, DN, RAND and clear the counter. If no nonzero phase remains:
  - REPEAT=0 → DONE.
  - REPEAT=1 → first nonzero phase of UP/DN/RAND; RESET is not repeated; the LFSR is not reseeded.
  - If all three are zero → DONE, regardless of REPEAT.
- stop in any state → IDLE with idle outputs on the next edge. The LFSR value is kept.
- start while busy is ignored. Reset mid-sequence gives the reset values on the next edge.

## Timing
- Latency: start sampled at edge E → RESET outputs are visible from E (registered) for RST_CYCLES cycles.
- Total busy cycles = RST_CYCLES + UP_CYCLES + DN_CYCLES + RAND_CYCLES.
- done rises on the cycle after the last RAND cycle.
- Defaults, counting cycles from the start edge as cycle 0:
  - cycle 0: g_rst_n=0.
  - cycles 1–2: up.
  - cycles 3–5: down.
  - cycles 6–21: random.
  - cycle 22: done=1, busy=0.
- No combinational path from any input to any output.

## Structure
- Package stim_pkg: state enum stim_state_t, LFSR_W=16, LFSR tap constant, DEFAULT_SEED.
- Sub-module stim_lfsr: 16-bit LFSR with ports clk, rst_n, load, seed, adv, q.
- Elaboration checks: NCH ≤ 8, RST_CYCLES ≥ 1, SEED ≠ 0, all phase lengths < 2**CNT_W.

## Test plan
- Defaults, start pulse at cycle 0 → exact cycle map above; busy high for cycles 0–21; done=1 from cycle 22; both counter channels end at 2−3+Σ(random steps).
- RAND first two cycles with SEED=16'hACE1 → LFSR goes ACE1 → 59C3.
  - Cycle 6: ch0 en=1 up=0; ch1 en=0 up=0.
  - Cycle 7: ch0 en=1 up=1; ch1 en=0 up=0.
- UP_CYCLES=0, DN_CYCLES=0 → RESET is followed directly by RAND; total busy = 17 cycles.
- REPEAT=1, RAND_CYCLES=4 → UP/DN/RAND loops with period 9 and done never asserts. stop at cycle 30 → cycle 31 IDLE: g_rst_n=1, g_en=0, busy=0.
- start asserted during UP → ignored; second start in DONE → sequence restarts with LFSR reseeded and an identical random pattern.
- rst_n low at cycle 10 → next edge: g_rst_n=0, g_en=0, busy=0; after release → IDLE with g_rst_n=1.

Source files
------------

// File: rtl/stim_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : stim_pkg                                                      |
// | Purpose  : Shared types and constants for the stimulus sequencer:        |
// |            state encoding, LFSR width/taps/seed and the LFSR step.       |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package stim_pkg;

  localparam int LFSR_W = 16;

  // Feedback taps for x^16+x^14+x^13+x^11+1, expressed as bit positions
  // 15, 13, 12 and 10 of the register before the left shift.
  localparam logic [LFSR_W-1:0] LFSR_TAPS    = 16'hB400;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_UP    = 3'd2,
    ST_DN    = 3'd3,
    ST_RAND  = 3'd4,
    ST_DONE  = 3'd5
  } stim_state_t;

  // One Fibonacci step: shift left, feedback parity enters at bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/stim_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : stim_sequencer_if                                             |
// | Purpose  : Control and stimulus bundle between the sequencer and the     |
// |            counter channels it exercises.                                |
// | Ports    : start/stop (control in), g_rst_n, g_en[NCH], g_up_dn[NCH],    |
// |            busy, done (stimulus/status out). master = sequencer side.    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface stim_sequencer_if #(
  parameter int NCH = 2
);
  logic           start;
  logic           stop;
  logic           g_rst_n;
  logic [NCH-1:0] g_en;
  logic [NCH-1:0] g_up_dn;
  logic           busy;
  logic           done;

  modport master (
    input  start, stop,
    output g_rst_n, g_en, g_up_dn, busy, done
  );

  modport slave (
    output start, stop,
    input  g_rst_n, g_en, g_up_dn, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/stim_sequencer_lfsr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : stim_lfsr                                                     |
// | Purpose  : 16-bit Fibonacci LFSR with synchronous seed load and advance. |
// | Ports    : clk, rst_n (sync, active low), load, seed[16], adv, q[16].    |
// |            load has priority over adv.                                   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module stim_lfsr
  import stim_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RESET_SEED = DEFAULT_SEED
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              adv,
  output logic [LFSR_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= RESET_SEED;
    end else if (load) begin
      q <= seed;
    end else if (adv) begin
      q <= lfsr_step(q);
    end
  end

endmodule
`default_nettype wire

// File: rtl/stim_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : stim_sequencer                                                |
// | Purpose  : Drives reset / enable / direction into NCH up/down counter    |
// |            channels: RESET, then directed UP and DN phases, then an      |
// |            LFSR-driven RAND phase; one pass or looping.                  |
// | Ports    : clk, rst_n (sync, active low), bus (stim_sequencer_if.master: |
// |            start, stop in; g_rst_n, g_en, g_up_dn, busy, done out).      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module stim_sequencer
  import stim_pkg::*;
#(
  parameter int                NCH         = 2,
  parameter int                CNT_W       = 8,
  parameter int                RST_CYCLES  = 1,
  parameter int                UP_CYCLES   = 2,
  parameter int                DN_CYCLES   = 3,
  parameter int                RAND_CYCLES = 16,
  parameter logic [LFSR_W-1:0] SEED        = DEFAULT_SEED,
  parameter bit                REPEAT      = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  stim_sequencer_if.master bus
);

  // ---------------------------------------------------------------- checks
  if (NCH < 1 || NCH > 8) begin : g_chk_nch
    $error("stim_sequencer: NCH must be in 1..8");
  end
  if (RST_CYCLES < 1) begin : g_chk_rst
    $error("stim_sequencer: RST_CYCLES must be >= 1");
  end
  if (SEED == '0) begin : g_chk_seed
    $error("stim_sequencer: SEED must be nonzero");
  end
  if (RST_CYCLES  >= (1 << CNT_W) || UP_CYCLES   >= (1 << CNT_W) ||
      DN_CYCLES   >= (1 << CNT_W) || RAND_CYCLES >= (1 << CNT_W)) begin : g_chk_len
    $error("stim_sequencer: phase length does not fit in CNT_W");
  end

  // ------------------------------------------------------------ constants
  localparam bit HAS_UP   = (UP_CYCLES   != 0);
  localparam bit HAS_DN   = (DN_CYCLES   != 0);
  localparam bit HAS_RAND = (RAND_CYCLES != 0);

  // Terminal counts; zero-length phases are never entered, so their
  // wrapped value is irrelevant.
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES  - 1);
  localparam logic [CNT_W-1:0] UP_LAST   = CNT_W'(UP_CYCLES   - 1);
  localparam logic [CNT_W-1:0] DN_LAST   = CNT_W'(DN_CYCLES   - 1);
  localparam logic [CNT_W-1:0] RAND_LAST = CNT_W'(RAND_CYCLES - 1);

  // ------------------------------------------------------ phase ordering
  function automatic stim_state_t first_phase();
    if (HAS_UP)        return ST_UP;
    else if (HAS_DN)   return ST_DN;
    else if (HAS_RAND) return ST_RAND;
    else               return ST_DONE;
  endfunction

  // End of the UP/DN/RAND chain: loop (never back through RESET) or finish.
  function automatic stim_state_t wrap_phase();
    if (REPEAT) return first_phase();
    else        return ST_DONE;
  endfunction

  function automatic stim_state_t after_dn();
    if (HAS_RAND) return ST_RAND;
    else          return wrap_phase();
  endfunction

  function automatic stim_state_t after_up();
    if (HAS_DN) return ST_DN;
    else        return after_dn();
  endfunction

  // Channel i takes enable from bit 2i and direction from bit 2i+1.
  function automatic logic [NCH-1:0] pick_en(input logic [LFSR_W-1:0] v);
    logic [NCH-1:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++) r[i] = v[2*i];
    return r;
  endfunction

  function automatic logic [NCH-1:0] pick_dir(input logic [LFSR_W-1:0] v);
    logic [NCH-1:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++) r[i] = v[2*i+1];
    return r;
  endfunction

  // ---------------------------------------------------------------- state
  stim_state_t       state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [LFSR_W-1:0] lfsr_q;
  logic [LFSR_W-1:0] rand_src;
  logic              lfsr_load, lfsr_adv;

  logic              g_rst_n_q, g_rst_n_nxt;
  logic [NCH-1:0]    g_en_q, g_en_nxt;
  logic [NCH-1:0]    g_up_dn_q, g_up_dn_nxt;
  logic              busy_q, busy_nxt;
  logic              done_q, done_nxt;

  stim_lfsr #(
    .RESET_SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (SEED),
    .adv   (lfsr_adv),
    .q     (lfsr_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      g_rst_n_q <= 1'b0;
      g_en_q    <= '0;
      g_up_dn_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      g_rst_n_q <= g_rst_n_nxt;
      g_en_q    <= g_en_nxt;
      g_up_dn_q <= g_up_dn_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + CNT_W'(1);
    lfsr_load   = 1'b0;
    lfsr_adv    = 1'b0;
    g_rst_n_nxt = 1'b1;
    g_en_nxt    = '0;
    g_up_dn_nxt = '0;
    busy_nxt    = 1'b0;
    done_nxt    = 1'b0;

    case (state)
      ST_IDLE, ST_DONE: begin
        cnt_nxt = cnt;
        if (bus.start) begin
          state_nxt = ST_RESET;
          cnt_nxt   = '0;
          lfsr_load = 1'b1;
        end
      end
      ST_RESET: begin
        if (cnt == RST_LAST) begin
          state_nxt = first_phase();
          cnt_nxt   = '0;
        end
      end
      ST_UP: begin
        if (cnt == UP_LAST) begin
          state_nxt = after_up();
          cnt_nxt   = '0;
        end
      end
      ST_DN: begin
        if (cnt == DN_LAST) begin
          state_nxt = after_dn();
          cnt_nxt   = '0;
        end
      end
      ST_RAND: begin
        lfsr_adv = 1'b1;
        if (cnt == RAND_LAST) begin
          state_nxt = wrap_phase();
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Abort wins over everything and freezes the LFSR where it is.
    if (bus.stop) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      lfsr_load = 1'b0;
      lfsr_adv  = 1'b0;
    end

    // Outputs are registered alongside the state, so they are decoded from
    // the next state. A RAND cycle shows the LFSR value it will hold during
    // that cycle: the current value on entry, the stepped value while the
    // register is advancing.
    rand_src = (state == ST_RAND) ? lfsr_step(lfsr_q) : lfsr_q;

    case (state_nxt)
      ST_RESET: begin
        g_rst_n_nxt = 1'b0;
        busy_nxt    = 1'b1;
      end
      ST_UP: begin
        g_en_nxt    = '1;
        g_up_dn_nxt = '1;
        busy_nxt    = 1'b1;
      end
      ST_DN: begin
        g_en_nxt    = '1;
        busy_nxt    = 1'b1;
      end
      ST_RAND: begin
        g_en_nxt    = pick_en(rand_src);
        g_up_dn_nxt = pick_dir(rand_src);
        busy_nxt    = 1'b1;
      end
      ST_DONE: begin
        done_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.g_rst_n = g_rst_n_q;
  assign bus.g_en    = g_en_q;
  assign bus.g_up_dn = g_up_dn_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_stim_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_stim_sequencer                                             |
// | Purpose  : Directed self-checking bench for stim_sequencer. Three        |
// |            instances: defaults, UP/DN skipped, and looping with a short  |
// |            random phase. Outputs are sampled on the falling edge.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_stim_sequencer;

  localparam int K_IDLE  = 0;
  localparam int K_RESET = 1;
  localparam int K_UP    = 2;
  localparam int K_DN    = 3;
  localparam int K_RAND  = 4;
  localparam int K_DONE  = 5;
  localparam int K_RSTV  = 6;  // values while rst_n is low

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stop2 = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stim_sequencer_if #(.NCH(2)) bus0 ();
  stim_sequencer_if #(.NCH(2)) bus1 ();
  stim_sequencer_if #(.NCH(2)) bus2 ();

  assign bus0.start = start;
  assign bus0.stop  = 1'b0;
  assign bus1.start = start;
  assign bus1.stop  = 1'b0;
  assign bus2.start = start;
  assign bus2.stop  = stop2;

  stim_sequencer dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  stim_sequencer #(
    .UP_CYCLES (0),
    .DN_CYCLES (0)
  ) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  stim_sequencer #(
    .RAND_CYCLES (4),
    .REPEAT      (1'b1)
  ) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  // Two up/down counters standing in for the channels driven by dut0.
  int cnt0 [2] = '{0, 0};
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!bus0.g_rst_n)       cnt0[i] <= 0;
      else if (bus0.g_en[i])   cnt0[i] <= bus0.g_up_dn[i] ? cnt0[i] + 1 : cnt0[i] - 1;
    end
  end

  function automatic logic [15:0] nxt(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Expected {g_rst_n, g_en[1:0], g_up_dn[1:0], busy, done}.
  function automatic logic [6:0] exp_vec(input int kind, input logic [15:0] v);
    case (kind)
      K_IDLE:  return 7'b1_00_00_00;
      K_RESET: return 7'b0_00_00_10;
      K_UP:    return 7'b1_11_11_10;
      K_DN:    return 7'b1_11_00_10;
      K_RAND:  return {1'b1, v[2], v[0], v[3], v[1], 2'b10};
      K_DONE:  return 7'b1_00_00_01;
      default: return 7'b0_00_00_00;
    endcase
  endfunction

  function automatic logic [6:0] obs0();
    return {bus0.g_rst_n, bus0.g_en, bus0.g_up_dn, bus0.busy, bus0.done};
  endfunction
  function automatic logic [6:0] obs1();
    return {bus1.g_rst_n, bus1.g_en, bus1.g_up_dn, bus1.busy, bus1.done};
  endfunction
  function automatic logic [6:0] obs2();
    return {bus2.g_rst_n, bus2.g_en, bus2.g_up_dn, bus2.busy, bus2.done};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulses start, then checks every cycle 0..last. with2 also checks the
  // looping instance and stops it at cycle 30; poke issues a start while busy.
  task automatic run_seq(input string name, input int last, input bit with2, input bit poke);
    logic [15:0] m0, m1, m2;
    int          k0, k1, k2;
    int          sum [2];
    logic [15:0] v;
    m0  = 16'hACE1;
    m1  = 16'hACE1;
    m2  = 16'hACE1;
    sum = '{0, 0};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c <= last; c++) begin
      if (c > 0) @(negedge clk);

      // instance 0: defaults
      v = m0;
      if (c == 0)       k0 = K_RESET;
      else if (c <= 2)  k0 = K_UP;
      else if (c <= 5)  k0 = K_DN;
      else if (c <= 21) k0 = K_RAND;
      else              k0 = K_DONE;
      chk($sformatf("%s d0 c%0d", name, c), 32'(obs0()), 32'(exp_vec(k0, v)));
      if (k0 == K_RAND) begin
        for (int i = 0; i < 2; i++)
          if (v[2*i]) sum[i] += v[2*i+1] ? 1 : -1;
        m0 = nxt(m0);
      end
      if (c == 6) chk($sformatf("%s d0 rand0 en/dir", name), 32'({bus0.g_en, bus0.g_up_dn}), 32'h4);
      if (c == 7) chk($sformatf("%s d0 rand1 en/dir", name), 32'({bus0.g_en, bus0.g_up_dn}), 32'h5);
      if (c == 22) begin
        for (int i = 0; i < 2; i++)
          chk($sformatf("%s ch%0d count", name, i), 32'(cnt0[i]), 32'(2 - 3 + sum[i]));
      end

      // instance 1: UP/DN skipped
      if (c == 0)       k1 = K_RESET;
      else if (c <= 16) k1 = K_RAND;
      else              k1 = K_DONE;
      chk($sformatf("%s d1 c%0d", name, c), 32'(obs1()), 32'(exp_vec(k1, m1)));
      if (k1 == K_RAND) m1 = nxt(m1);

      // instance 2: looping, period 9 after the reset cycle
      if (with2) begin
        if (c == 0)                 k2 = K_RESET;
        else if (c == 31)           k2 = K_IDLE;
        else if ((c - 1) % 9 < 2)   k2 = K_UP;
        else if ((c - 1) % 9 < 5)   k2 = K_DN;
        else                        k2 = K_RAND;
        chk($sformatf("%s d2 c%0d", name, c), 32'(obs2()), 32'(exp_vec(k2, m2)));
        if (k2 == K_RAND) m2 = nxt(m2);
        if (c == 30) stop2 = 1'b1;
        if (c == 31) stop2 = 1'b0;
      end

      if (poke) begin
        if (c == 1) start = 1'b1;
        if (c == 2) start = 1'b0;
      end
    end
  endtask

  initial begin
    // Reset values, then idle after release.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset d0", 32'(obs0()), 32'(exp_vec(K_RSTV, 16'h0)));
    chk("reset d1", 32'(obs1()), 32'(exp_vec(K_RSTV, 16'h0)));
    chk("reset d2", 32'(obs2()), 32'(exp_vec(K_RSTV, 16'h0)));
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle d0", 32'(obs0()), 32'(exp_vec(K_IDLE, 16'h0)));
    chk("idle d2", 32'(obs2()), 32'(exp_vec(K_IDLE, 16'h0)));

    // Full pass, start pulsed during UP, loop instance stopped at cycle 30.
    run_seq("run1", 31, 1'b1, 1'b1);

    // Restart from DONE: same map and same random pattern.
    run_seq("run2", 23, 1'b0, 1'b0);

    // Reset in the middle of a sequence.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid busy d0", 32'(bus0.busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst d0", 32'(obs0()), 32'(exp_vec(K_RSTV, 16'h0)));
    chk("midrst d1", 32'(obs1()), 32'(exp_vec(K_RSTV, 16'h0)));
    chk("midrst d2", 32'(obs2()), 32'(exp_vec(K_RSTV, 16'h0)));
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst d0", 32'(obs0()), 32'(exp_vec(K_IDLE, 16'h0)));
    chk("postrst d2", 32'(obs2()), 32'(exp_vec(K_IDLE, 16'h0)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
